// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-RAM interface. Takes one load or
// store at a time from the datapath and issues word-wide RAM reads/writes.
// Sub-word loads are lane-extracted and extended; sub-word stores are done as
// read-modify-write. Misaligned/illegal/out-of-range requests never touch RAM.
//
// state | meaning
// IDLE  | ready for a request
// READ  | RAM read strobe; fetched word feeds load result or store merge
// WRITE | RAM write strobe with the full word to commit
// RESP  | one-cycle response pulse
module mem_access_unit #(
  parameter int RAM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        read_ram,
  output logic        write_ram,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_out
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;

  logic accept;
  logic req_err;

  // Select the addressed lane of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane(s) of a fetched word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) res[{lane, 3'b000} +: 8] = wdata[7:0];
    else               res[{lane[1], 4'b0000} +: 16] = wdata;
    return res;
  endfunction

  assign accept = req_valid & req_ready;

  // Request legality: alignment, size encoding and word range.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(RAM_WORDS)) req_err = 1'b1;
  end

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          err_d   = req_err;
          if (req_err) begin
            rdata_d = 32'h0;
            state_d = RESP;
          end else begin
            ram_addr_d = {2'b00, req_addr[31:2]};
            if (req_write && req_size == 2'b10) begin
              ram_wdata_d = req_wdata;
              state_d     = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (write_q) begin
          ram_wdata_d = store_merge(ram_out, wdata_q, size_q, lane_q);
          state_d     = WRITE;
        end else begin
          rdata_d = load_extract(ram_out, size_q, lane_q, uns_q);
          state_d = RESP;
        end
      end
      WRITE: begin
        rdata_d = 32'h0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Strobes are gated by rst_n so nothing reaches the RAM during reset.
  assign req_ready      = (state_q == IDLE) & rst_n;
  assign read_ram       = (state_q == READ) & rst_n;
  assign write_ram      = (state_q == WRITE) & rst_n;
  assign resp_valid     = (state_q == RESP);
  assign resp_err       = err_q;
  assign resp_rdata     = rdata_q;
  assign ram_addr       = ram_addr_q;
  assign ram_write_data = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural RAM + request-level reference model,
// per-cycle compare against the expected strobe/response timeline.
module tb_mem_access_unit;
  localparam int RW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        read_ram, write_ram;
  logic [31:0] ram_addr, ram_write_data, ram_out;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_WORDS(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .read_ram(read_ram), .write_ram(write_ram),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_out(ram_out)
  );

  function automatic bit [31:0] init_word(input int i);
    if (i == 3) return 32'h8081F0F1;
    if (i == 5) return 32'h11223344;
    return 32'hA5000000 | (32'(i) * 32'h00010101);
  endfunction

  // Behavioural RAM attached to the DUT.
  logic [31:0] mem [0:RW-1];
  logic        mem_inited = 1'b0;
  assign ram_out = (ram_addr < RW) ? mem[ram_addr[3:0]] : 32'h0;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < RW; i++) mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (write_ram && ram_addr < RW) begin
      mem[ram_addr[3:0]] <= ram_write_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle timeline, filled by the driver from the reference model.
  bit        exp_rd [0:1023];
  bit        exp_wr [0:1023];
  bit        exp_rv [0:1023];
  bit        exp_err [0:1023];
  bit        exp_busy [0:1023];
  bit [31:0] exp_addr [0:1023];
  bit [31:0] exp_wd [0:1023];
  bit [31:0] exp_rdata [0:1023];
  bit [31:0] ref_mem [0:RW-1];

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (cycle %0d)", name, got, exp, cyc);
  endtask

  // Per-cycle compare of DUT outputs against the expected timeline.
  always @(negedge clk) begin
    if (chk_en && cyc < 1024) begin
      check_bit("read_ram", read_ram, exp_rd[cyc]);
      check_bit("write_ram", write_ram, exp_wr[cyc]);
      check_bit("resp_valid", resp_valid, exp_rv[cyc]);
      check_bit("req_ready", req_ready, rst_n & ~exp_busy[cyc]);
      if (exp_rd[cyc] || exp_wr[cyc]) check("ram_addr", ram_addr, exp_addr[cyc]);
      if (exp_wr[cyc]) check("ram_write_data", ram_write_data, exp_wd[cyc]);
      if (exp_rv[cyc]) begin
        check_bit("resp_err", resp_err, exp_err[cyc]);
        check("resp_rdata", resp_rdata, exp_rdata[cyc]);
      end
    end
  end

  // Issue one request, predict its full timeline; abort=1 resets in the WRITE cycle.
  task automatic do_req(input bit wr, input bit [1:0] sz, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wd, input bit abort);
    int a, len, shift, t;
    bit err, sb;
    bit [31:0] wi, mask, word, val, nw;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check_bit("ready_timeout", req_ready, 1'b1);
      return;
    end
    a     = cyc + 1;
    wi    = addr >> 2;
    mask  = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    shift = (sz == 2'd0) ? 8 * int'(addr[1:0]) : (sz == 2'd1) ? 16 * int'(addr[1]) : 0;
    err   = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)
            || (wi >= RW);
    len   = 1;
    if (err) begin
      exp_rv[a] = 1'b1; exp_err[a] = 1'b1; exp_rdata[a] = 32'h0;
    end else begin
      word = ref_mem[wi[3:0]];
      if (!wr) begin
        len = 2;
        val = (word >> shift) & mask;
        sb  = (sz == 2'd0) ? val[7] : val[15];
        if (!uns && sz != 2'd2 && sb) val = val | ~mask;
        exp_rd[a] = 1'b1; exp_addr[a] = wi;
        exp_rv[a+1] = 1'b1; exp_err[a+1] = 1'b0; exp_rdata[a+1] = val;
      end else if (sz == 2'd2) begin
        len = 2;
        exp_wr[a] = 1'b1; exp_addr[a] = wi; exp_wd[a] = wd;
        exp_rv[a+1] = 1'b1; exp_err[a+1] = 1'b0; exp_rdata[a+1] = 32'h0;
        ref_mem[wi[3:0]] = wd;
      end else begin
        len = 3;
        nw = (word & ~(mask << shift)) | ((wd & mask) << shift);
        exp_rd[a] = 1'b1; exp_addr[a] = wi;
        if (!abort) begin
          exp_wr[a+1] = 1'b1; exp_addr[a+1] = wi; exp_wd[a+1] = nw;
          exp_rv[a+2] = 1'b1; exp_err[a+2] = 1'b0; exp_rdata[a+2] = 32'h0;
          ref_mem[wi[3:0]] = nw;
        end
      end
    end
    if (abort) len = 2;
    for (int i = 0; i < len; i++) exp_busy[a+i] = 1'b1;
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~wr; req_size = ~sz; req_unsigned = ~uns; req_addr = ~addr; req_wdata = ~wd;
    if (abort) begin
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
    end else begin
      repeat (len) @(negedge clk);
      #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < RW; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    check_bit("rst_read_ram", read_ram, 1'b0);
    check_bit("rst_write_ram", write_ram, 1'b0);
    check_bit("rst_req_ready_low", req_ready, 1'b0);
    check_bit("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_write_data", ram_write_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check_bit("ready_after_rst", req_ready, 1'b1);
    chk_en = 1'b1;

    // loads from word 3 = 0x8081F0F1
    do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 1'b0);
    check("lw_0c", resp_rdata, 32'h8081F0F1);
    do_req(1'b0, 2'd0, 1'b0, 32'h0D, 32'h0, 1'b0);
    check("lb_0d", resp_rdata, 32'hFFFFFFF0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0F, 32'h0, 1'b0);
    check("lbu_0f", resp_rdata, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, 1'b0);
    check("lh_0e", resp_rdata, 32'hFFFF8081);
    do_req(1'b0, 2'd1, 1'b1, 32'h0C, 32'h0, 1'b0);
    check("lhu_0c", resp_rdata, 32'h0000F0F1);

    // stores
    do_req(1'b1, 2'd0, 1'b0, 32'h16, 32'hFFFFFFAB, 1'b0);
    check("sb_16_ram", mem[5], 32'h11AB3344);
    check("sb_16_rdata", resp_rdata, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
    check("sw_20_ram", mem[8], 32'hDEADBEEF);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h12345678, 1'b0);
    check("sh_22_ram", mem[8], 32'h5678BEEF);
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 1'b0);
    check("lb_23", resp_rdata, 32'h00000056);
    do_req(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 1'b0);
    check("lw_3c_last_word", resp_rdata, init_word(15));

    // errors
    do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 1'b0);
    check_bit("err_lh_01", resp_err, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0);
    check_bit("err_lw_06", resp_err, 1'b1);
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 1'b0);
    check_bit("err_size3", resp_err, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);
    check_bit("err_lw_40", resp_err, 1'b1);
    do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h77, 1'b0);
    check_bit("err_sb_41", resp_err, 1'b1);
    check("err_rdata", resp_rdata, 32'h0);

    // reset during the WRITE cycle of a byte store
    do_req(1'b1, 2'd0, 1'b0, 32'h14, 32'h99, 1'b1);
    @(negedge clk);
    #1;
    check_bit("abort_ready", req_ready, 1'b1);
    check("abort_ram_unchanged", mem[5], 32'h11AB3344);
    check("abort_rdata", resp_rdata, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
    check("lw_14_after_abort", resp_rdata, 32'h11AB3344);

    repeat (2) @(negedge clk);
    for (int i = 0; i < RW; i++) check("ram_contents", mem[i], ref_mem[i]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the data-RAM interface: accepts one load or store request at a time from the CPU datapath and turns it into `read_ram`/`write_ram` transactions on the word-wide RAM. It handles byte, halfword and word accesses. Sub-word loads are extracted and extended; sub-word stores are done as read-modify-write. Misaligned and out-of-range accesses are flagged without touching the RAM. It sits between the execute stage and the RAM.

## Interface
- `RAM_WORDS`, 16, number of 32-bit words in the attached RAM; legal word addresses are 0..RAM_WORDS-1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle pulse, request complete.
- `resp_err` out 1: qualifies `resp_valid`; misaligned, illegal size, or out of range.
- `resp_rdata` out 32: load result, extended to 32 bits.
- `read_ram` out 1: RAM read strobe.
- `write_ram` out 1: RAM write strobe.
- `ram_addr` out 32: word address, equal to `req_addr[31:2]` zero-extended.
- `ram_write_data` out 32: full word to write.
- `ram_out` in 32: RAM read data, valid in the same cycle as `read_ram`.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- `req_ready` = 1 only in IDLE with `rst_n` = 1.
- A request is accepted on `req_valid & req_ready`. All request fields are registered at that edge and the inputs are ignored afterwards.
- Error check at accept:
  - halfword with `addr[0]`=1 is an error;
  - word with `addr[1:0]`≠0 is an error;
  - `req_size`=11 is an error;
  - `addr[31:2]` ≥ RAM_WORDS is an error.
- Transitions from IDLE on accept:
  - error → RESP (no RAM access);
  - load → READ;
  - word store → WRITE;
  - byte or halfword store → READ.
- READ: `read_ram`=1 and `ram_addr` valid. `ram_out` is captured into the word buffer at the end of the cycle. Next state is RESP for a load, WRITE for a store.
- WRITE: `write_ram`=1. `ram_write_data` is the full `req_wdata` for a word store. For a sub-word store it is the buffered word with only the target lane(s) replaced. Next state is RESP.
- RESP: `resp_valid`=1 for exactly one cycle. Next state is IDLE.
- Lanes are little-endian.
  - Byte lane k = `addr[1:0]` occupies bits [8k+7:8k].
  - Halfword lane = `addr[1]`, occupying bits [16·addr[1]+15 : 16·addr[1]].
- Store merge: byte store takes `req_wdata[7:0]`; halfword store takes `req_wdata[15:0]`.
- Load result: the selected lane, sign- or zero-extended per `req_unsigned`. Word loads pass `ram_out` through unchanged.
- `resp_rdata` is 0 for stores and errors. It holds its value until the next RESP.
- `read_ram` and `write_ram` are never both 1, and are 0 outside READ/WRITE respectively.

## Timing
- Accept at edge N. Latency to `resp_valid`:
  - error: cycle N+1;
  - word store: WRITE in cycle N+1, RESP in N+2;
  - load: READ in N+1, RESP in N+2;
  - sub-word store: READ in N+1, WRITE in N+2, RESP in N+3.
- `req_ready` returns to 1 in the cycle after RESP. There is no overlap, so the maximum rate is one request per 3 cycles.
- No response backpressure: `resp_valid` is a fire-and-forget pulse.
- `ram_addr` and `ram_write_data` are stable for the whole READ/WRITE cycle. Outside those states they hold their last value.
- Reset (`rst_n`=0 at an edge), values after the edge:
  - state = IDLE;
  - `resp_valid`, `resp_err`, `resp_rdata`, `ram_addr`, `ram_write_data` = 0;
  - `req_ready` = 1 once `rst_n` is high.
- `read_ram` and `write_ram` are combinationally gated by `rst_n`. No RAM access is issued in any cycle where `rst_n`=0.
- Reset mid-operation aborts the request:
  - a pending sub-word or word store whose WRITE cycle coincides with `rst_n`=0 is not committed;
  - no response is produced for the aborted request.
- `req_valid` asserted while `req_ready`=0 is ignored. The requester must hold it until accepted.

## Test plan
- Word load: RAM[3]=0x8081F0F1, load word at addr 0x0C → `read_ram` in N+1 with `ram_addr`=3; `resp_valid` in N+2 with `resp_rdata`=0x8081F0F1 and `resp_err`=0.
- Sub-word loads from the same word:
  - signed byte at 0x0D → 0xFFFFFFF0;
  - unsigned byte at 0x0F → 0x00000080;
  - signed half at 0x0E → 0xFFFF8081.
- Byte store: RAM[5]=0x11223344, store byte 0xAB at 0x16 → READ in N+1, WRITE in N+2 with `ram_write_data`=0x11AB3344, `resp_valid` in N+3.
- Word store: store 0xDEADBEEF at 0x20 → `write_ram` in N+1 only, RAM[8]=0xDEADBEEF, `resp_valid` in N+2.
- Errors, each giving `resp_err`=1 in N+1 with no `read_ram`/`write_ram` at any point:
  - half at 0x01;
  - word at 0x06;
  - size 11;
  - word at 0x40 (word 16 with RAM_WORDS=16).
- Reset mid-op: start a byte store, drive `rst_n`=0 in the WRITE cycle → `write_ram` stays 0, RAM is unchanged, no `resp_valid`, and `req_ready`=1 in the first cycle after reset is released.
